// File: rtl/reg_hazard_pkg.sv
// Shared types and constants for the register hazard / forwarding controller.
// Contents:
//   REG_ADDR_W       register address width that the entry type is built on
//   FWD_*            encodings of the EX operand mux selects
//   haz_entry_t      one in-flight destination record {valid, addr, is_load}
//   mk_entry()       builds an entry; writes to r0 never become valid
package reg_hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } haz_entry_t;

  // r0 is hard-wired to zero, so a write to it is dropped here and can never
  // produce a hazard or a forward further down the shadow pipeline.
  function automatic haz_entry_t mk_entry(input logic                  wr_en,
                                          input logic [REG_ADDR_W-1:0] addr,
                                          input logic                  is_load);
    haz_entry_t e;
    e.valid   = wr_en && (addr != '0);
    e.addr    = addr;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/reg_hazard_ctrl_match.sv
// Combinational comparison of one ID-stage source register against the EX,
// MEM and WB shadow entries.
// Ports:
//   src_i     source register address
//   use_i     instruction actually reads this source
//   ex_i      EX-stage shadow entry
//   mem_i     MEM-stage shadow entry
//   wb_i      WB-stage shadow entry
//   match_o   {WB, MEM, EX} match bits
//   sel_o     priority-encoded forward select (nearest producer wins)
module hazard_match
  import reg_hazard_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic              use_i,
  input  haz_entry_t        ex_i,
  input  haz_entry_t        mem_i,
  input  haz_entry_t        wb_i,
  output logic [2:0]        match_o,
  output logic [1:0]        sel_o
);

  // A source of r0 never depends on anything.
  logic src_live;
  assign src_live = use_i && (src_i != '0);

  assign match_o[0] = src_live && ex_i.valid  && (ex_i.addr  == src_i);
  assign match_o[1] = src_live && mem_i.valid && (mem_i.addr == src_i);
  assign match_o[2] = src_live && wb_i.valid  && (wb_i.addr  == src_i);

  // WB needs no forward: the register file writes before it is read.
  always_comb begin
    sel_o = FWD_RF;
    if (match_o[0])      sel_o = FWD_EXMEM;
    else if (match_o[1]) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline register file.
// Tracks in-flight destinations for EX/MEM/WB, raises a load-use stall for
// the ID instruction and registers the EX operand forward selects.
// Ports:
//   clk_i          pipeline clock, all state on posedge
//   rst_i          synchronous active-high reset
//   id_valid_i     ID holds a real instruction
//   id_rs_i/rt_i   source A/B addresses
//   id_use_rs_i    instruction reads rs
//   id_use_rt_i    instruction reads rt
//   id_wr_en_i     instruction writes a register
//   id_wr_addr_i   destination register
//   id_is_load_i   instruction is a load (data ready at end of MEM)
//   flush_i        kill the ID instruction
//   stall_o        hold PC and IF/ID (combinational)
//   ex_fwd_a_o     EX operand A select (0 regfile, 1 EX/MEM, 2 MEM/WB)
//   ex_fwd_b_o     EX operand B select
//   stall_cnt_o    saturating count of stall cycles since reset
module reg_hazard_ctrl
  import reg_hazard_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_wr_en_i,
  input  logic [ADDR_W-1:0] id_wr_addr_i,
  input  logic              id_is_load_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [1:0]        ex_fwd_a_o,
  output logic [1:0]        ex_fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  haz_entry_t ex_q, mem_q, wb_q;
  haz_entry_t ex_d;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Index 0 = rs (operand A), 1 = rt (operand B).
  logic [1:0][ADDR_W-1:0] src;
  logic [1:0]             src_use;
  logic [1:0][2:0]        match;
  logic [1:0][1:0]        sel;

  assign src     = {id_rt_i, id_rs_i};
  assign src_use = {id_use_rt_i, id_use_rs_i};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hazard_match #(.ADDR_W(ADDR_W)) u_match (
      .src_i   (src[g]),
      .use_i   (src_use[g]),
      .ex_i    (ex_q),
      .mem_i   (mem_q),
      .wb_i    (wb_q),
      .match_o (match[g]),
      .sel_o   (sel[g])
    );
  end

  logic stall, bubble;

  // Load in EX feeding the ID instruction: its data only exists at the end
  // of MEM, so hold one cycle. Flush kills the consumer, so no stall then.
  assign stall  = !rst_i && id_valid_i && !flush_i && ex_q.is_load &&
                  (match[0][0] || match[1][0]);
  assign bubble = stall || flush_i || !id_valid_i;

  always_comb begin
    ex_d        = '0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    stall_cnt_d = stall_cnt_q;
    if (!bubble) begin
      ex_d    = mk_entry(id_wr_en_i, id_wr_addr_i, id_is_load_i);
      fwd_a_d = sel[0];
      fwd_b_d = sel[1];
    end
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign ex_fwd_a_o  = fwd_a_q;
  assign ex_fwd_b_o  = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;

  // WB matches and late-stage load flags carry no action; they are kept so
  // the shadow pipeline is complete for observation.
  logic unused_bits;
  assign unused_bits = ^{match[0][2:1], match[1][2:1], mem_q.is_load, wb_q.is_load};

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
module tb_reg_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;
  logic [AW-1:0] id_rs, id_rt, id_wr_addr;
  logic          stall;
  logic [1:0]    ex_fwd_a, ex_fwd_b;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  reg_hazard_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_use_rs_i  (id_use_rs),
    .id_use_rt_i  (id_use_rt),
    .id_wr_en_i   (id_wr_en),
    .id_wr_addr_i (id_wr_addr),
    .id_is_load_i (id_is_load),
    .flush_i      (flush),
    .stall_o      (stall),
    .ex_fwd_a_o   (ex_fwd_a),
    .ex_fwd_b_o   (ex_fwd_b),
    .stall_cnt_o  (stall_cnt)
  );

  typedef struct {
    logic          rst, vld;
    logic [AW-1:0] rs, rt;
    logic          urs, urt, we;
    logic [AW-1:0] wa;
    logic          ld, fl;
    logic          xst;
    logic [1:0]    xfa, xfb;
    logic [CW-1:0] xcnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input int rs_, input int rt_,
                              input logic urs_, input logic urt_, input logic we_, input int wa_,
                              input logic ld_, input logic fl_, input logic xst_,
                              input int xfa_, input int xfb_, input int xcnt_);
    vec_t t;
    t.rst = r;  t.vld = v;  t.rs = AW'(rs_); t.rt = AW'(rt_);
    t.urs = urs_; t.urt = urt_; t.we = we_; t.wa = AW'(wa_);
    t.ld = ld_; t.fl = fl_; t.xst = xst_;
    t.xfa = 2'(xfa_); t.xfb = 2'(xfb_); t.xcnt = CW'(xcnt_);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; id_valid = t.vld; id_rs = t.rs; id_rt = t.rt;
    id_use_rs = t.urs; id_use_rt = t.urt; id_wr_en = t.we; id_wr_addr = t.wa;
    id_is_load = t.ld; flush = t.fl;
  endtask

  initial begin
    vec_t lw_chain;
    int   ecnt;
    logic est;

    //              rst vld rs rt urs urt we wa ld fl | st fa fb cnt
    vecs[0]  = mk(1, 1,  3, 3, 1, 1, 1,  5, 1, 0,  0, 0, 0, 0); // reset
    vecs[1]  = mk(0, 1,  1, 2, 1, 1, 1,  3, 0, 0,  0, 0, 0, 0); // add r3,r1,r2
    vecs[2]  = mk(0, 1,  3, 5, 1, 1, 1,  4, 0, 0,  0, 1, 0, 0); // sub r4,r3,r5: dist 1
    vecs[3]  = mk(0, 1,  1, 1, 1, 1, 1,  6, 0, 0,  0, 0, 0, 0); // or r6
    vecs[4]  = mk(0, 1,  2, 4, 1, 1, 1,  7, 0, 0,  0, 0, 2, 0); // and r7,r2,r4: dist 2
    vecs[5]  = mk(0, 1,  4, 4, 1, 1, 1, 10, 0, 0,  0, 0, 0, 0); // r4 at dist 3
    vecs[6]  = mk(0, 1,  1, 1, 1, 1, 1, 10, 0, 0,  0, 0, 0, 0); // r10 again
    vecs[7]  = mk(0, 1, 10,10, 1, 1, 0,  0, 0, 0,  0, 1, 1, 0); // EX and MEM both r10
    vecs[8]  = mk(0, 1,  1, 0, 1, 0, 1,  8, 1, 0,  0, 0, 0, 0); // lw r8
    vecs[9]  = mk(0, 1,  8, 8, 1, 1, 1,  9, 0, 0,  1, 0, 0, 1); // add r9,r8,r8: stall
    vecs[10] = mk(0, 1,  8, 8, 1, 1, 1,  9, 0, 0,  0, 2, 2, 1); // reissue after stall
    vecs[11] = mk(0, 1,  1, 0, 1, 0, 1,  0, 1, 0,  0, 0, 0, 1); // lw r0
    vecs[12] = mk(0, 1,  0, 0, 1, 1, 1, 11, 0, 0,  0, 0, 0, 1); // reads r0
    vecs[13] = mk(0, 1,  1, 0, 1, 0, 1,  8, 1, 0,  0, 0, 0, 1); // lw r8
    vecs[14] = mk(0, 1,  8, 2, 0, 1, 1, 12, 0, 0,  0, 0, 0, 1); // rs=8 unused
    vecs[15] = mk(0, 1,  1, 0, 1, 0, 1,  8, 1, 0,  0, 0, 0, 1); // lw r8
    vecs[16] = mk(0, 1,  8, 8, 1, 1, 1, 13, 0, 1,  0, 0, 0, 1); // hazard + flush
    vecs[17] = mk(0, 1,  8, 5, 1, 1, 1, 14, 0, 0,  0, 2, 0, 1); // lw now in MEM
    vecs[18] = mk(0, 0, 14,14, 1, 1, 1, 15, 0, 0,  0, 0, 0, 1); // id_valid=0
    vecs[19] = mk(0, 1, 15,15, 1, 1, 0,  0, 0, 0,  0, 0, 0, 1); // invalid slot was bubble
    vecs[20] = mk(0, 1,  1, 1, 1, 1, 1,  3, 0, 0,  0, 0, 0, 1); // add r3
    vecs[21] = mk(0, 1,  1, 0, 1, 0, 1,  8, 1, 0,  0, 0, 0, 1); // lw r8 (r3 -> MEM)
    vecs[22] = mk(1, 1,  3, 8, 1, 1, 1, 16, 0, 0,  0, 0, 0, 0); // rst over hazards
    vecs[23] = mk(0, 1,  3, 8, 1, 1, 0,  0, 0, 0,  0, 0, 0, 0); // nothing in flight

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), int'(stall), int'(vecs[i].xst));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d fwd_a", i), int'(ex_fwd_a), int'(vecs[i].xfa));
      chk($sformatf("v%0d fwd_b", i), int'(ex_fwd_b), int'(vecs[i].xfb));
      chk($sformatf("v%0d stall_cnt", i), int'(stall_cnt), int'(vecs[i].xcnt));
    end

    // Back-to-back load-use: lw r8,0(r8) repeated stalls every other cycle
    // and drives the 3-bit counter into saturation.
    lw_chain = mk(0, 1, 8, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0);
    ecnt = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(lw_chain);
      #1;
      est = (k % 2) == 1;
      chk($sformatf("sat%0d stall", k), int'(stall), int'(est));
      @(posedge clk);
      #1;
      if (est && ecnt != 7) ecnt++;
      chk($sformatf("sat%0d stall_cnt", k), int'(stall_cnt), ecnt);
      chk($sformatf("sat%0d fwd_a", k), int'(ex_fwd_a), (est || k == 0) ? 0 : 2);
    end

    // Reset clears the saturated counter.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("final rst stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
